// File: rtl/adder_pipe.sv
// Two-stage streaming signed adder/subtractor/accumulator with valid/ready
// flow control, signed overflow flag and optional saturation.
module adder_pipe #(
  parameter int unsigned BIT_WIDTH = 16,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           op,
  input  logic [BIT_WIDTH-1:0] A0,
  input  logic [BIT_WIDTH-1:0] A1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] Y,
  output logic                 ovf
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  localparam logic [BIT_WIDTH-1:0] SAT_MAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] SAT_MIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

  op_e                  s1_op;
  logic                 s1_valid;
  logic [BIT_WIDTH-1:0] s1_a0;
  logic [BIT_WIDTH-1:0] s1_a1;
  logic [BIT_WIDTH-1:0] acc;

  logic                 stall;
  logic [BIT_WIDTH:0]   a0_x;
  logic [BIT_WIDTH:0]   a1_x;
  logic [BIT_WIDTH:0]   acc_x;
  logic [BIT_WIDTH:0]   r;
  logic [BIT_WIDTH-1:0] y_c;
  logic                 ovf_c;
  logic                 acc_we;

  // Whole pipeline freezes on a stalled output, even if S1 is empty.
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  assign a0_x  = {s1_a0[BIT_WIDTH-1], s1_a0};
  assign a1_x  = {s1_a1[BIT_WIDTH-1], s1_a1};
  assign acc_x = {acc[BIT_WIDTH-1], acc};

  always_comb begin
    r = '0;
    unique case (s1_op)
      OP_ADD:  r = a0_x + a1_x;
      OP_SUB:  r = a0_x - a1_x;
      OP_ACC:  r = acc_x + a0_x;
      OP_LOAD: r = a0_x;
      default: r = '0;
    endcase
  end

  always_comb begin
    ovf_c = (s1_op != OP_LOAD) && (r[BIT_WIDTH] != r[BIT_WIDTH-1]);
    y_c   = r[BIT_WIDTH-1:0];
    if (SATURATE && ovf_c) begin
      y_c = r[BIT_WIDTH] ? SAT_MIN : SAT_MAX;
    end
    acc_we = (s1_op == OP_ACC) || (s1_op == OP_LOAD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_ADD;
      s1_a0    <= '0;
      s1_a1    <= '0;
    end else if (!stall) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_op <= op_e'(op);
        s1_a0 <= A0;
        s1_a1 <= A1;
      end
    end
  end

  // acc is written on the same edge as Y, so a following accumulate beat
  // already sees it without any hazard bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      Y         <= '0;
      ovf       <= 1'b0;
      acc       <= '0;
    end else if (!stall) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        Y   <= y_c;
        ovf <= ovf_c;
        if (acc_we) begin
          acc <= y_c;
        end
      end
    end
  end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, streaming successor to the team's registered two-operand adder. It registers operands and the result, like the previous generation, and adds the following:
- valid/ready flow control with full backpressure;
- a per-beat opcode selecting add, subtract, accumulate or accumulator load;
- signed overflow detection with optional saturation.

It sits between a producer and a consumer stream wherever a fixed-latency signed arithmetic stage is needed.

## Interface
- BIT_WIDTH, 16, operand/result width (≥2)
- SATURATE, 0, 0 = two's-complement wrap on overflow, 1 = clamp to signed max/min
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer beat valid
- in_ready  output  1  block can accept a beat this cycle
- op  input  2  00 add A0+A1, 01 sub A0−A1, 10 accumulate acc+A0, 11 load acc=A0
- A0  input  BIT_WIDTH  signed operand 0
- A1  input  BIT_WIDTH  signed operand 1 (ignored for op 10/11)
- out_valid  output  1  result beat valid
- out_ready  input  1  consumer accepts result
- Y  output  BIT_WIDTH  signed result
- ovf  output  1  signed overflow occurred for this beat (before any saturation)

## Operation
- Reset (asserted, async): s1_valid=0, out_valid=0, Y=0, ovf=0, acc=0, operand/op registers=0. in_ready=1 once reset deasserts.
- Two register stages:
  - S1 captures {op, A0, A1} on in_valid & in_ready.
  - S2 computes and registers {Y, ovf, out_valid}.
- stall = out_valid & ~out_ready. in_ready = ~stall. When stall=1, every pipeline register holds, acc included. When stall=0, both stages advance: s1_valid←in_valid; out_valid←s1_valid.
- Bubbles are not compressed. An empty S1 while S2 is stalled still blocks input, so throughput is 1 beat/cycle only when out_ready=1.
- Arithmetic in S2, computed at BIT_WIDTH+1 bits from sign-extended operands:
  - 00: r = A0+A1.
  - 01: r = A0−A1.
  - 10: r = acc+A0.
  - 11: r = A0, with ovf forced 0.
- Overflow: ovf = r[BIT_WIDTH] ≠ r[BIT_WIDTH−1].
  - SATURATE=0: Y = r[BIT_WIDTH−1:0].
  - SATURATE=1 and ovf: Y = 0111…1 if r is positive, 1000…0 if negative; otherwise Y = r low bits.
- Accumulator updates only when an S1 beat with op 10 or 11 advances into S2: acc←Y (the post-saturation value). Ops 00/01 leave acc unchanged.
- Accumulate beats issued back-to-back see the acc value written by the immediately preceding beat, with no hazard bubble, because acc is updated in the same edge that registers Y.
- Y and ovf hold their last value while out_valid=0. Consumers must qualify with out_valid.

## Timing
- Latency: a beat accepted at rising edge N appears with out_valid=1 after edge N+1. It is consumed at the first edge ≥N+1 where out_ready=1.
- in_ready is combinational from out_valid and out_ready only. There is no path from in_valid to in_ready.
- Simultaneous accept and emit in one cycle is allowed and required for full throughput.
- Reset asserted mid-stream discards all in-flight beats and clears acc immediately, with no clock needed. The first edge after deassertion may accept a beat.
- Y, ovf and out_valid are driven directly from flops.

## Test plan
- Reset/latency, BIT_WIDTH=16:
  - Stimulus: release rst_n, send op=00 A0=3, A1=4 at edge N.
  - Required: Y=7, ovf=0, out_valid=1 after edge N+1. All outputs 0 during reset.
- Wrap vs saturate:
  - Stimulus: op=00, A0=0x7FFF, A1=0x0001.
  - Required with SATURATE=0: Y=0x8000, ovf=1.
  - Required with SATURATE=1: Y=0x7FFF, ovf=1.
  - Then op=01 with A0=0x8000, A1=1: SATURATE=1 gives Y=0x8000, ovf=1.
- Accumulate chain:
  - Stimulus: back-to-back beats op=11 A0=10; op=10 A0=5; op=10 A0=−20; op=00 A0=1, A1=1.
  - Required: Y sequence 10, 15, −5, 2 on consecutive cycles; acc ends at −5.
- Backpressure:
  - Stimulus: stream 8 sequential add beats with out_ready toggled randomly, plus a 5-cycle low burst.
  - Required: while out_ready is low, in_ready=0 and Y is stable. All 8 results arrive in order, with none lost or duplicated.
- Reset mid-operation:
  - Stimulus: load acc=100, put 2 beats in flight, assert rst_n low between edges.
  - Required: out_valid, Y and acc go to 0 immediately. After release, op=10 A0=1 yields Y=1.
- Full throughput: with out_ready held high, 16 back-to-back beats produce 16 consecutive out_valid cycles with in_ready continuously 1.
